// File: rtl/pcm_sample_fifo.sv
// rtl/pcm_sample_fifo.sv - FWFT sample FIFO between the PCM rate divider and the correlation readout
module pcm_sample_fifo #(
   parameter int DW    = 16,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we_pcm,
   input  logic [DW-1:0] pcm_in,
   input  logic          cap_en,
   output logic [DW-1:0] dout,
   output logic          dout_valid,
   input  logic          dout_ready,
   output logic [AW:0]   level,
   output logic          full,
   output logic          empty,
   output logic          overflow,
   input  logic          clr_ovf
);

   localparam logic [AW:0] LP_DEPTH = DEPTH[AW:0];

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic          r_full;
   logic          r_empty;
   logic          r_valid;
   logic          r_ovf;
   logic [DW-1:0] r_last;

   logic          w_push;
   logic          w_drop;
   logic          w_pop;
   logic [AW:0]   w_level_nxt;

   // Full gates the write even when a pop happens in the same cycle.
   assign w_push = we_pcm & cap_en & ~r_full;
   assign w_drop = we_pcm & cap_en & r_full;
   assign w_pop  = r_valid & dout_ready;

   always_comb begin
      w_level_nxt = r_level;
      if (w_push && !w_pop) begin
         w_level_nxt = r_level + (AW+1)'(1);
      end else if (w_pop && !w_push) begin
         w_level_nxt = r_level - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_valid  <= 1'b0;
         r_ovf    <= 1'b0;
         r_last   <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_level <= w_level_nxt;
         r_full  <= (w_level_nxt == LP_DEPTH);
         r_empty <= (w_level_nxt == '0);
         r_valid <= (w_level_nxt != '0);
         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (clr_ovf) begin
            r_ovf <= 1'b0;
         end
         // Keeps dout stable at the last presented sample once the FIFO drains.
         if (r_valid) r_last <= r_mem[r_rd_ptr];
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= pcm_in;
   end

   assign dout       = r_valid ? r_mem[r_rd_ptr] : r_last;
   assign dout_valid = r_valid;
   assign level      = r_level;
   assign full       = r_full;
   assign empty      = r_empty;
   assign overflow   = r_ovf;

endmodule

// File: tb/tb_pcm_sample_fifo.sv
// tb/tb_pcm_sample_fifo.sv - randomized and directed bench for pcm_sample_fifo against a queue model
module tb_pcm_sample_fifo;

   localparam int DW    = 16;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk;
   logic          rst;
   logic          we_pcm;
   logic [DW-1:0] pcm_in;
   logic          cap_en;
   logic [DW-1:0] dout;
   logic          dout_valid;
   logic          dout_ready;
   logic [AW:0]   level;
   logic          full;
   logic          empty;
   logic          overflow;
   logic          clr_ovf;

   int n_vec;
   int n_err;

   logic [DW-1:0] m_q [$];
   logic          m_ovf;

   pcm_sample_fifo #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .we_pcm     (we_pcm),
      .pcm_in     (pcm_in),
      .cap_en     (cap_en),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .level      (level),
      .full       (full),
      .empty      (empty),
      .overflow   (overflow),
      .clr_ovf    (clr_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("level", 32'(level), 32'(m_q.size()));
      chk("full", 32'(full), 32'(m_q.size() == DEPTH));
      chk("empty", 32'(empty), 32'(m_q.size() == 0));
      chk("dout_valid", 32'(dout_valid), 32'(m_q.size() != 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (m_q.size() != 0) chk("dout", 32'(dout), 32'(m_q[0]));
   endtask

   // Called at a falling edge; applies one cycle of inputs and checks the result.
   task automatic step(input logic we, input logic cap, input logic rdy,
                       input logic clr, input logic [DW-1:0] din);
      bit m_full, push, drop, pop;
      we_pcm = we; cap_en = cap; dout_ready = rdy; clr_ovf = clr; pcm_in = din;
      m_full = (m_q.size() == DEPTH);
      push   = we && cap && !m_full;
      drop   = we && cap && m_full;
      pop    = (m_q.size() != 0) && rdy;
      @(posedge clk);
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(din);
      if (drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      we_pcm = 0; cap_en = 0; dout_ready = 0; clr_ovf = 0; pcm_in = '0;
      #2 rst = 1'b0;
      #1;
      m_q.delete();
      m_ovf = 1'b0;
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_valid", 32'(dout_valid), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_dout", 32'(dout), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0;
      we_pcm = 0; cap_en = 0; dout_ready = 0; clr_ovf = 0; pcm_in = '0;
      n_vec = 0;
      n_err = 0;
      m_ovf = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Idle reads after reset must never underflow.
      do_reset();
      for (int i = 0; i < 3; i++) step(0, 1, 1, 0, '0);

      // Single sample through the FWFT path.
      step(1, 1, 0, 0, 16'hA5A5);
      chk("single_dout", 32'(dout), 32'h0000A5A5);
      step(0, 1, 1, 0, '0);
      chk("single_drained", 32'(level), 32'd0);

      // Fill past capacity, drain, then clear overflow.
      for (int i = 1; i <= 17; i++) step(1, 1, 0, 0, DW'(i));
      chk("fill_ovf", 32'(overflow), 32'd1);
      for (int i = 1; i <= 16; i++) begin
         chk("drain_seq", 32'(dout), 32'(i));
         step(0, 1, 1, 0, '0);
      end
      step(0, 1, 0, 1, '0);
      chk("clr_ovf", 32'(overflow), 32'd0);

      // Steady push+pop across pointer wrap.
      for (int i = 0; i < 3; i++) step(1, 1, 0, 0, DW'(16'h100 + i));
      for (int i = 0; i < 20; i++) step(1, 1, 1, 0, DW'(16'h200 + i));
      chk("pp_level", 32'(level), 32'd3);

      // Disabled capture ignores strobes, reads continue.
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0, DW'(16'h300 + i));
      for (int i = 0; i < 4; i++) step(1, 0, 1, 0, DW'(16'h400 + i));

      // A drop beats a simultaneous clear.
      for (int i = 0; i < 16; i++) step(1, 1, 0, 0, DW'(16'h500 + i));
      step(1, 1, 0, 1, 16'hDEAD);
      chk("ovf_priority", 32'(overflow), 32'd1);
      step(1, 0, 0, 1, 16'hBEEF);
      chk("ovf_cleared", 32'(overflow), 32'd0);
      for (int i = 0; i < 16; i++) step(0, 1, 1, 0, '0);

      // Divider with C=4 sampling a ramp.
      for (int c = 0; c < 40; c++) step((c % 4) == 0, 1, 0, 0, DW'(c));
      chk("div_level", 32'(level), 32'd10);
      for (int i = 0; i < 10; i++) begin
         chk("div_ramp", 32'(dout), 32'(i * 4));
         step(0, 1, 1, 0, '0);
      end

      // Randomized traffic with varying read pressure and one mid-run reset.
      for (int i = 0; i < 3000; i++) begin
         int rdy_pct;
         rdy_pct = ((i / 300) % 3 == 0) ? 15 : (((i / 300) % 3 == 1) ? 85 : 50);
         if (i == 1500) do_reset();
         step($urandom_range(99) < 60, $urandom_range(99) < 85,
              $urandom_range(99) < rdy_pct, $urandom_range(99) < 5,
              DW'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
